// File: rtl/int_inject_ctrl_if.sv
// Bus bundle between the P4 fetch/RI path, the decoder and the interrupt injection controller.
// The master side is the core/fetch environment; the slave side is int_inject_ctrl.
interface int_inject_ctrl_if #(
    parameter int N_CH  = 16,
    parameter int IW    = 16,
    parameter int VEC_W = 4
);
    logic [IW-1:0]    ri_in;
    logic             ri_load;
    logic             int_en;
    logic [N_CH-1:0]  int_req;
    logic [N_CH-1:0]  int_mask;
    logic [N_CH-1:0]  int_clr;
    logic [IW-1:0]    ri_out;
    logic             clock_en;
    logic             int_busy;
    logic [VEC_W-1:0] int_vec;
    logic [N_CH-1:0]  pending;

    modport master (
        output ri_in, ri_load, int_en, int_req, int_mask, int_clr,
        input  ri_out, clock_en, int_busy, int_vec, pending
    );

    modport slave (
        input  ri_in, ri_load, int_en, int_req, int_mask, int_clr,
        output ri_out, clock_en, int_busy, int_vec, pending
    );
endinterface

// File: rtl/int_inject_ctrl.sv
// Interrupt controller for the P4 core: latches request edges, prioritises unmasked channels and,
// at an instruction boundary, freezes the core one cycle then injects "INT vec" and a NOP.
module int_inject_ctrl #(
    parameter int                    N_CH     = 16,
    parameter int                    IW       = 16,
    parameter int                    VEC_W    = 4,
    parameter logic [IW-VEC_W-1:0]   INT_OPC  = 12'b010001110000,
    parameter logic [IW-1:0]         NOP_WORD = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    int_inject_ctrl_if.slave   bus
);

    generate
        if (N_CH < 1 || N_CH > (1 << VEC_W)) begin : g_bad_n_ch
            $error("int_inject_ctrl: N_CH must be in 1..2**VEC_W");
        end
        if (IW <= VEC_W) begin : g_bad_iw
            $error("int_inject_ctrl: IW must exceed VEC_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        INJECT = 2'd2,
        NOP    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              clock_en_q, clock_en_nxt;
    logic [VEC_W-1:0]  int_vec_q;
    logic [N_CH-1:0]   req_d;
    logic [N_CH-1:0]   pending_q;
    logic [IW-1:0]     ri_hold;
    logic [IW-1:0]     ri_out_c;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   win_oh;
    logic [VEC_W-1:0]  win;
    logic              found;
    logic              take;
    logic [N_CH-1:0]   clr_svc;

    assign rise     = bus.int_req & ~req_d;
    assign eligible = pending_q & ~bus.int_mask;

    // Lowest set index wins; channel 0 has the highest priority.
    always_comb begin
        win    = '0;
        win_oh = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (eligible[i] && !found) begin
                win       = VEC_W'(i);
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign take    = (state == IDLE) && bus.int_en && found && bus.ri_load;
    assign clr_svc = take ? win_oh : '0;

    always_comb begin
        state_nxt    = state;
        clock_en_nxt = 1'b1;
        ri_out_c     = bus.ri_in;
        case (state)
            IDLE: begin
                if (take) begin
                    clock_en_nxt = 1'b0;
                    state_nxt    = STALL;
                end
            end
            STALL: begin
                // Replay the boundary instruction the core could not consume.
                ri_out_c  = ri_hold;
                state_nxt = INJECT;
            end
            INJECT: begin
                ri_out_c  = {INT_OPC, int_vec_q};
                state_nxt = NOP;
            end
            NOP: begin
                ri_out_c  = NOP_WORD;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clock_en_q <= 1'b0;
            int_vec_q  <= '0;
            req_d      <= '0;
            pending_q  <= '0;
            ri_hold    <= '0;
        end else begin
            state      <= state_nxt;
            clock_en_q <= clock_en_nxt;
            req_d      <= bus.int_req;
            // A new edge wins over both the service clear and the software clear.
            pending_q  <= (pending_q & ~clr_svc & ~bus.int_clr) | rise;
            if (take) begin
                int_vec_q <= win;
            end
            if (clock_en_q && (state == IDLE)) begin
                ri_hold <= bus.ri_in;
            end
        end
    end

    assign bus.ri_out   = ri_out_c;
    assign bus.clock_en = clock_en_q;
    assign bus.int_busy = (state != IDLE);
    assign bus.int_vec  = int_vec_q;
    assign bus.pending  = pending_q;

endmodule

// File: tb/tb_int_inject_ctrl.sv
// Directed table-driven bench for int_inject_ctrl, plus hand sequences for reset behaviour.
module tb_int_inject_ctrl;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    int_inject_ctrl_if #(.N_CH(16), .IW(16), .VEC_W(4)) bus ();

    int_inject_ctrl #(
        .N_CH    (16),
        .IW      (16),
        .VEC_W   (4),
        .INT_OPC (12'b010001110000),
        .NOP_WORD(16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ri_in;
        logic        ri_load;
        logic        int_en;
        logic [15:0] req;
        logic [15:0] mask;
        logic [15:0] clr;
        logic [15:0] e_ri_out;
        logic        e_ce;
        logic        e_busy;
        logic [3:0]  e_vec;
        logic [15:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] ri, input logic ld, input logic en,
                       input logic [15:0] req, input logic [15:0] mask, input logic [15:0] clr,
                       input logic [15:0] eo, input logic ece, input logic eb,
                       input logic [3:0] ev, input logic [15:0] ep);
        vec_t v;
        v.ri_in = ri; v.ri_load = ld; v.int_en = en; v.req = req; v.mask = mask; v.clr = clr;
        v.e_ri_out = eo; v.e_ce = ece; v.e_busy = eb; v.e_vec = ev; v.e_pend = ep;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ri, input logic ld, input logic en,
                         input logic [15:0] req, input logic [15:0] mask, input logic [15:0] clr);
        bus.ri_in = ri; bus.ri_load = ld; bus.int_en = en;
        bus.int_req = req; bus.int_mask = mask; bus.int_clr = clr;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [15:0] eo,
                           input logic ece, input logic eb, input logic [3:0] ev,
                           input logic [15:0] ep);
        chk({tag, ".ri_out"},   idx, bus.ri_out, eo);
        chk({tag, ".clock_en"}, idx, {15'd0, bus.clock_en}, {15'd0, ece});
        chk({tag, ".int_busy"}, idx, {15'd0, bus.int_busy}, {15'd0, eb});
        chk({tag, ".int_vec"},  idx, {12'd0, bus.int_vec}, {12'd0, ev});
        chk({tag, ".pending"},  idx, bus.pending, ep);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // ch5 single interrupt
        add(16'h1111,1,1,16'h0000,0,0, 16'h1111,1,0,4'h0,16'h0000);
        add(16'h1112,0,1,16'h0020,0,0, 16'h1112,1,0,4'h0,16'h0000);
        add(16'h1113,1,1,16'h0020,0,0, 16'h1113,1,0,4'h0,16'h0020);
        add(16'h1114,0,1,16'h0020,0,0, 16'h1113,0,1,4'h5,16'h0000);
        add(16'h1114,0,1,16'h0020,0,0, 16'h4705,1,1,4'h5,16'h0000);
        add(16'h1114,0,1,16'h0020,0,0, 16'h0000,1,1,4'h5,16'h0000);
        add(16'h1114,0,1,16'h0000,0,0, 16'h1114,1,0,4'h5,16'h0000);
        // ch3 and ch9 in the same cycle
        add(16'h2001,0,1,16'h0208,0,0, 16'h2001,1,0,4'h5,16'h0000);
        add(16'h2002,1,1,16'h0208,0,0, 16'h2002,1,0,4'h5,16'h0208);
        add(16'h2003,1,1,16'h0208,0,0, 16'h2002,0,1,4'h3,16'h0200);
        add(16'h2003,0,1,16'h0208,0,0, 16'h4703,1,1,4'h3,16'h0200);
        add(16'h2003,0,1,16'h0208,0,0, 16'h0000,1,1,4'h3,16'h0200);
        add(16'h2004,1,1,16'h0208,0,0, 16'h2004,1,0,4'h3,16'h0200);
        add(16'h2005,0,1,16'h0208,0,0, 16'h2004,0,1,4'h9,16'h0000);
        add(16'h2005,0,1,16'h0208,0,0, 16'h4709,1,1,4'h9,16'h0000);
        add(16'h2005,0,1,16'h0208,0,0, 16'h0000,1,1,4'h9,16'h0000);
        add(16'h2006,0,1,16'h0000,0,0, 16'h2006,1,0,4'h9,16'h0000);
        // masked ch2, then unmask
        add(16'h3001,1,1,16'h0004,16'h0004,0, 16'h3001,1,0,4'h9,16'h0000);
        add(16'h3002,1,1,16'h0004,16'h0004,0, 16'h3002,1,0,4'h9,16'h0004);
        add(16'h3003,1,1,16'h0004,16'h0004,0, 16'h3003,1,0,4'h9,16'h0004);
        add(16'h3004,1,1,16'h0004,16'h0000,0, 16'h3004,1,0,4'h9,16'h0004);
        add(16'h3005,0,1,16'h0004,16'h0000,0, 16'h3004,0,1,4'h2,16'h0000);
        add(16'h3005,0,1,16'h0004,16'h0000,0, 16'h4702,1,1,4'h2,16'h0000);
        add(16'h3005,0,1,16'h0004,16'h0000,0, 16'h0000,1,1,4'h2,16'h0000);
        add(16'h3006,0,1,16'h0000,16'h0000,0, 16'h3006,1,0,4'h2,16'h0000);
        // int_en=0 holds ch1 pending; then waits for ri_load; changes mid-sequence ignored
        add(16'h4001,1,0,16'h0002,0,0, 16'h4001,1,0,4'h2,16'h0000);
        add(16'h4002,1,0,16'h0002,0,0, 16'h4002,1,0,4'h2,16'h0002);
        add(16'h4003,1,0,16'h0000,0,0, 16'h4003,1,0,4'h2,16'h0002);
        add(16'h4004,0,1,16'h0000,0,0, 16'h4004,1,0,4'h2,16'h0002);
        add(16'h4005,0,1,16'h0000,0,0, 16'h4005,1,0,4'h2,16'h0002);
        add(16'h4006,1,1,16'h0000,0,0, 16'h4006,1,0,4'h2,16'h0002);
        add(16'h4007,0,0,16'h0000,16'hFFFF,16'hFFFF, 16'h4006,0,1,4'h1,16'h0000);
        add(16'h4007,0,0,16'h0000,16'hFFFF,16'hFFFF, 16'h4701,1,1,4'h1,16'h0000);
        add(16'h4007,0,0,16'h0000,16'hFFFF,16'hFFFF, 16'h0000,1,1,4'h1,16'h0000);
        add(16'h4008,0,1,16'h0000,0,0, 16'h4008,1,0,4'h1,16'h0000);
        // software clear, set-beats-clear, merge, new edge during a sequence
        add(16'h5001,0,1,16'h0001,0,0, 16'h5001,1,0,4'h1,16'h0000);
        add(16'h5002,0,1,16'h0000,0,16'h0001, 16'h5002,1,0,4'h1,16'h0001);
        add(16'h5003,0,1,16'h0010,0,16'h0010, 16'h5003,1,0,4'h1,16'h0000);
        add(16'h5004,0,1,16'h0000,0,0, 16'h5004,1,0,4'h1,16'h0010);
        add(16'h5005,0,1,16'h0010,0,0, 16'h5005,1,0,4'h1,16'h0010);
        add(16'h5006,1,1,16'h0010,0,0, 16'h5006,1,0,4'h1,16'h0010);
        add(16'h5007,0,1,16'h0040,0,0, 16'h5006,0,1,4'h4,16'h0000);
        add(16'h5007,0,1,16'h0040,0,0, 16'h4704,1,1,4'h4,16'h0040);
        add(16'h5007,0,1,16'h0040,0,0, 16'h0000,1,1,4'h4,16'h0040);
        add(16'h5008,1,1,16'h0000,0,0, 16'h5008,1,0,4'h4,16'h0040);
        add(16'h5009,0,1,16'h0000,0,0, 16'h5008,0,1,4'h6,16'h0000);
        add(16'h5009,0,1,16'h0000,0,0, 16'h4706,1,1,4'h6,16'h0000);
        add(16'h5009,0,1,16'h0000,0,0, 16'h0000,1,1,4'h6,16'h0000);
        add(16'h500A,0,1,16'h0000,0,0, 16'h500A,1,0,4'h6,16'h0000);
        // highest channel, vector 15
        add(16'h6001,0,1,16'h8000,0,0, 16'h6001,1,0,4'h6,16'h0000);
        add(16'h6002,1,1,16'h8000,0,0, 16'h6002,1,0,4'h6,16'h8000);
        add(16'h6003,0,1,16'h8000,0,0, 16'h6002,0,1,4'hF,16'h0000);
        add(16'h6003,0,1,16'h8000,0,0, 16'h470F,1,1,4'hF,16'h0000);
        add(16'h6003,0,1,16'h8000,0,0, 16'h0000,1,1,4'hF,16'h0000);
        add(16'h6004,0,1,16'h0000,0,0, 16'h6004,1,0,4'hF,16'h0000);

        // Reset state and idle pass-through
        reset = 1'b1;
        drive(16'hABCD, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge clock);
        #1 chk_all("reset", 0, 16'hABCD, 0, 0, 4'h0, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        drive(16'hA000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        #1 chk_all("release", 0, 16'hA000, 0, 0, 4'h0, 16'h0000);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            drive(16'hA000 + 16'(i), 0, 0, 16'h0000, 16'h0000, 16'h0000);
            #1 chk_all("idle", i, 16'hA000 + 16'(i), 1, 0, 4'h0, 16'h0000);
        end

        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i].ri_in, tbl[i].ri_load, tbl[i].int_en, tbl[i].req, tbl[i].mask, tbl[i].clr);
            #1 chk_all("table", i, tbl[i].e_ri_out, tbl[i].e_ce, tbl[i].e_busy,
                       tbl[i].e_vec, tbl[i].e_pend);
        end

        // Reset asserted while INT is on ri_out
        @(negedge clock);
        drive(16'h7001, 0, 1, 16'h0080, 16'h0000, 16'h0000);
        @(negedge clock);
        drive(16'h7002, 1, 1, 16'h0080, 16'h0000, 16'h0000);
        #1 chk_all("pre_rst", 0, 16'h7002, 1, 0, 4'hF, 16'h0080);
        @(negedge clock);
        drive(16'h7003, 0, 1, 16'h0080, 16'h0000, 16'h0000);
        #1 chk_all("pre_rst", 1, 16'h7002, 0, 1, 4'h7, 16'h0000);
        @(negedge clock);
        drive(16'h7003, 0, 1, 16'h0180, 16'h0000, 16'h0000);
        #1 chk_all("pre_rst", 2, 16'h4707, 1, 1, 4'h7, 16'h0000);
        #1 reset = 1'b1;
        #1 chk_all("mid_rst", 0, 16'h7003, 0, 0, 4'h0, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            drive(16'h7100 + 16'(i), 1, 1, (i == 2) ? 16'h0200 : 16'h0000, 16'h0000, 16'h0000);
            #1 chk_all("mid_rst", i, 16'h7100 + 16'(i), 0, 0, 4'h0, 16'h0000);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(16'h7200, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clock);
        drive(16'h7201, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        #1 chk_all("post_rst", 0, 16'h7201, 1, 0, 4'h0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
